// File: rtl/vector_mem_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vector_mem_sequencer_if : request, scalar-memory and response bundle
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
interface vector_mem_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANES  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_base;
  logic [LANES*DATA_W-1:0] req_wdata;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_is_load;
  logic [LANES*DATA_W-1:0] resp_rdata;

  // Sequencer side
  modport slave (
    input  req_valid, req_we, req_base, req_wdata, mem_rdata, resp_ready,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_is_load, resp_rdata
  );

  // Execute stage / memory side
  modport master (
    output req_valid, req_we, req_base, req_wdata, mem_rdata, resp_ready,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_is_load, resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vector_mem_sequencer : serialises one vector load/store onto scalar memory
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module vector_mem_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANES  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  vector_mem_sequencer_if.slave  bus
);
  localparam int              LW        = $clog2(LANES);
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES*DATA_W-1:0] rdata_q, rdata_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [LW-1:0]           cap_lane_q, cap_lane_d;
  logic                    in_access;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      cap_lane_q <= '0;
    end else begin
      lane_q     <= lane_d;
      we_q       <= we_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_pend_q  <= rd_pend_d;
      cap_lane_q <= cap_lane_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    we_d       = we_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_pend_d  = 1'b0;
    cap_lane_d = lane_q;

    // Read data arrives one cycle after its access; the pending flag remembers
    // which lane slot it belongs to, so the last lane lands during DRAIN.
    if (rd_pend_q) begin
      rdata_d[cap_lane_q*DATA_W +: DATA_W] = bus.mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          base_d  = bus.req_base;
          wdata_d = bus.req_wdata;
          lane_d  = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rd_pend_d = ~we_q;
        lane_d    = lane_q + LW'(1);
        if (lane_q == LAST_LANE) begin
          state_d = we_q ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_access        = (state_q == S_ACCESS);
  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.mem_en       = in_access;
  assign bus.mem_we       = in_access & we_q;
  assign bus.mem_addr     = in_access ? (base_q + ADDR_W'(lane_q)) : '0;
  assign bus.mem_wdata    = in_access ? wdata_q[lane_q*DATA_W +: DATA_W] : '0;
  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_is_load = (state_q == S_RESP) & ~we_q;
  assign bus.resp_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vector_mem_sequencer : table-driven, directed and random checks
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vector_mem_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LANES  = 4;
  localparam int VW     = LANES*DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_mem_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  vector_mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a function of address and a per-test key.
  logic [DATA_W-1:0] rd_key = '0;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] key);
    logic [ADDR_W-1:0] t;
    t = a << 1;
    return DATA_W'(t) ^ key;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_fn(bus.mem_addr, rd_key);
  end

  typedef struct {
    int unsigned       c;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } acc_t;
  acc_t log_q[$];

  always @(negedge clk) begin
    if (bus.mem_en) begin
      log_q.push_back('{cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end else if (!rst) begin
      checks++;
      if (bus.mem_we || bus.mem_addr != '0 || bus.mem_wdata != '0) begin
        errors++;
        $display("FAIL idle_mem_zero: we=%0b addr=%0h wdata=%0h required all 0",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  // Reference: lane i of a load returns the memory word at base+i.
  function automatic logic [VW-1:0] exp_load(input logic [ADDR_W-1:0] base,
                                             input logic [DATA_W-1:0] key);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = mem_fn(base + ADDR_W'(i), key);
    return v;
  endfunction

  task automatic wait_resp(input bit disturb, output int k);
    k = 1;
    while (k <= 20 && !bus.resp_valid) begin
      if (disturb) begin
        bus.req_we    = 1'($urandom);
        bus.req_base  = $urandom;
        bus.req_wdata = rand_vec();
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic check_log(input string tag, input int unsigned acc, input logic we,
                           input logic [ADDR_W-1:0] base, input logic [VW-1:0] wdata);
    chk({tag, " access_count"}, VW'(log_q.size()), VW'(LANES));
    for (int i = 0; i < LANES && i < log_q.size(); i++) begin
      chk({tag, " access"},
          VW'({log_q[i].c, log_q[i].we, log_q[i].a, log_q[i].d}),
          VW'({acc + 32'(i), we, base + ADDR_W'(i), wdata[i*DATA_W +: DATA_W]}));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic do_op(input string tag, input logic we, input logic [ADDR_W-1:0] base,
                       input logic [VW-1:0] wdata, input int hold,
                       input logic [VW-1:0] exp_rdata, input int exp_lat);
    int k;
    int unsigned acc;
    logic [VW-1:0] held;
    log_q.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_base  = base;
    bus.req_wdata = wdata;
    chk({tag, " req_ready_idle"}, VW'(bus.req_ready), VW'(1));
    @(posedge clk); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
    wait_resp(1'b1, k);
    chk({tag, " latency"}, VW'(k), VW'(exp_lat));
    if (k > 20) begin
      do_reset();
      return;
    end
    chk({tag, " is_load"}, VW'(bus.resp_is_load), VW'(!we));
    chk({tag, " rdata"}, bus.resp_rdata, exp_rdata);
    held = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, VW'({bus.resp_valid, bus.req_ready, bus.resp_rdata}),
          VW'({1'b1, 1'b0, held}));
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({tag, " back_to_idle"}, VW'({bus.resp_valid, bus.req_ready}), VW'(2'b01));
    check_log(tag, acc, we, base, wdata);
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] base;
    logic [VW-1:0]     wdata;
    int                hold;
    logic [VW-1:0]     exp_rdata;
    int                exp_lat;
  } vec_t;

  vec_t             tbl[3];
  logic [VW-1:0]    model_rdata;
  logic [VW-1:0]    w2;
  logic [VW-1:0]    held_v;
  logic             r_we;
  logic [ADDR_W-1:0] r_base;
  logic [VW-1:0]    r_wdata;
  logic [VW-1:0]    r_exp;
  int               k;
  int unsigned      acc2;

  initial begin
    tbl[0] = '{1'b0, 32'h10, 128'h0, 0,
               {32'h26, 32'h24, 32'h22, 32'h20}, LANES + 2};
    tbl[1] = '{1'b1, 32'h3, {32'h20, 32'h12, 32'h8, 32'h5}, 1,
               {32'h26, 32'h24, 32'h22, 32'h20}, LANES + 1};
    tbl[2] = '{1'b0, 32'hFFFF_FFFE, 128'h0, 2,
               {32'h2, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFC}, LANES + 2};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_base   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        VW'({bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.resp_valid, bus.resp_is_load}),
        VW'({1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}));
    chk("reset_rdata", bus.resp_rdata, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_idle", VW'({bus.req_ready, bus.resp_valid}), VW'(2'b10));

    for (int t = 0; t < 3; t++) begin
      rd_key = '0;
      do_op($sformatf("tbl%0d", t), tbl[t].we, tbl[t].base, tbl[t].wdata,
            tbl[t].hold, tbl[t].exp_rdata, tbl[t].exp_lat);
    end
    model_rdata = tbl[2].exp_rdata;

    // Backpressure with a new request waiting; it must issue the edge after the handshake.
    rd_key = '0;
    log_q.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_base = 32'h40; bus.req_wdata = rand_vec();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(1'b0, k);
    chk("bp latency", VW'(k), VW'(LANES + 2));
    model_rdata = exp_load(32'h40, '0);
    chk("bp rdata", bus.resp_rdata, model_rdata);
    w2 = rand_vec();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_base = 32'h80; bus.req_wdata = w2;
    held_v = bus.resp_rdata;
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #1;
      chk("bp hold", VW'({bus.resp_valid, bus.resp_is_load, bus.req_ready, bus.mem_en, bus.resp_rdata}),
          VW'({1'b1, 1'b1, 1'b0, 1'b0, held_v}));
    end
    log_q.delete();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp release_idle", VW'({bus.resp_valid, bus.req_ready, bus.mem_en}), VW'(3'b010));
    @(posedge clk); #1;
    acc2 = cyc;
    bus.req_valid = 1'b0;
    chk("bp second_issue", VW'({bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
        VW'({1'b0, 1'b1, 1'b1, 32'h80, w2[DATA_W-1:0]}));
    wait_resp(1'b1, k);
    chk("bp store_latency", VW'(k), VW'(LANES + 1));
    chk("bp store_rdata", bus.resp_rdata, model_rdata);
    chk("bp store_is_load", VW'(bus.resp_is_load), VW'(0));
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check_log("bp store", acc2, 1'b1, 32'h80, w2);

    // Asynchronous reset in the middle of a load.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_base = 32'h100; bus.req_wdata = rand_vec();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset lane1", VW'({bus.mem_en, bus.mem_addr}), VW'({1'b1, 32'h101}));
    #2 rst = 1'b1;
    #1;
    chk("mid_reset outputs",
        VW'({bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.resp_valid, bus.resp_is_load}),
        VW'({1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}));
    chk("mid_reset rdata", bus.resp_rdata, '0);
    model_rdata = '0;
    #2 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("post_reset no_resp", VW'({bus.resp_valid, bus.req_ready}), VW'(2'b01));
    end
    rd_key = 32'h5A5A_0F0F;
    r_exp = exp_load(32'h200, rd_key);
    do_op("post_reset load", 1'b0, 32'h200, rand_vec(), 0, r_exp, LANES + 2);
    model_rdata = r_exp;

    // Randomised operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_we    = 1'($urandom);
      r_base  = $urandom;
      if (n % 8 == 0) r_base = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      r_wdata = rand_vec();
      rd_key  = $urandom;
      if (!r_we) model_rdata = exp_load(r_base, rd_key);
      do_op($sformatf("rand%0d", n), r_we, r_base, r_wdata, $urandom_range(0, 3),
            model_rdata, r_we ? LANES + 1 : LANES + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
Sequences a single vector load or store (LANES lanes, consecutive word addresses from a base) onto the single-ported scalar data memory, one lane per cycle. It sits between the vector execute stage and data memory. It accepts one request via valid/ready, issues the lane accesses at base+i, gathers load data into a packed vector, and returns a response via valid/ready.

Parameters:
DATA_W, 32, lane and memory word width
ADDR_W, 32, memory address width
LANES, 4, lanes per vector (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = vector store, 0 = vector load
req_base  in  ADDR_W  base address, lane i uses req_base+i
req_wdata  in  LANES*DATA_W  store data, lane i at [i*DATA_W +: DATA_W]
mem_en  out  1  memory access this cycle
mem_we  out  1  write strobe, qualified by mem_en
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid the cycle after a read access
resp_valid  out  1  operation complete
resp_ready  in  1  consumer accepts response
resp_is_load  out  1  completed op was a load
resp_rdata  out  LANES*DATA_W  gathered load data, lane packing as req_wdata

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, lane counter=0, latched request cleared, resp_rdata=0, all outputs 0 except req_ready=1. A partially executed operation is discarded. No response is produced for it.
- FSM states: IDLE, ACCESS, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid at the edge, latch req_we, req_base and req_wdata, set lane=0, and go to ACCESS. Later changes on req_* are ignored until the next acceptance.
- ACCESS: lasts exactly LANES cycles.
  - mem_en=1, mem_we=latched we, mem_addr=base+lane (modulo 2^ADDR_W, wraps), mem_wdata=wdata lane[lane].
  - lane increments each cycle.
  - After lane LANES-1: a load goes to DRAIN, a store goes to RESP.
- Load capture: mem_rdata sampled on the edge ending the cycle after each lane's read is written to resp_rdata lane slot. Lanes 0..LANES-2 are captured during ACCESS. Lane LANES-1 is captured in DRAIN.
- DRAIN: mem_en=0 for one cycle, then go to RESP.
- RESP: resp_valid=1 and resp_is_load=latched !we. Both are held stable, along with resp_rdata, until resp_ready=1. On that handshake edge, go to IDLE.
- req_ready is 0 in ACCESS, DRAIN and RESP. req_valid is not accepted there.
- Latency: accept edge E.
  - mem_en is high in the LANES cycles after E.
  - Store: resp_valid is first high in cycle E+LANES+1.
  - Load: resp_valid is first high in cycle E+LANES+2.
  - The next request can be accepted no earlier than the edge after the response handshake.
- Stores leave resp_rdata unchanged from its previous value.
- All outputs come from registers or state decode. There is no combinational path from any input to any output.
- mem_en=0 outside ACCESS. mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.

Test Plan:
- Load, base=0x10, memory model returns rdata=addr*2 one cycle later -> mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles with mem_we=0; resp_rdata lanes = 0x20,0x22,0x24,0x26; resp_is_load=1; resp_valid first high LANES+2 cycles after accept.
- Store, base=0x3, wdata lanes {0x5,0x8,0x12,0x20} -> mem writes (0x3,0x5),(0x4,0x8),(0x5,0x12),(0x6,0x20); resp_valid after LANES+1 cycles; resp_is_load=0; resp_rdata unchanged.
- Wrap, load at base=0xFFFFFFFE -> mem_addr sequence 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
- Backpressure: hold resp_ready=0 for 3 cycles while req_valid=1 with new request -> resp_valid and resp_rdata stable, req_ready=0, no mem_en. Release -> IDLE, second request accepted the next edge.
- Reset mid-load, asserted asynchronously between clock edges after lane 1 issued -> outputs 0 immediately, req_ready=1; after release no resp_valid, and the next load completes correctly.
- Input disturbance: change req_base/req_wdata/req_we during ACCESS -> issued addresses and data follow the latched values only.
